// File: rtl/e203_longp_pkg.sv
// Shared types for the long-pipe retire stage: buffer state, completion
// source and the registered writeback/exception payload.
package e203_longp_pkg;

  localparam int unsigned LP_XLEN = 32;

  typedef enum logic [1:0] {
    LP_EMPTY = 2'd0,
    LP_WB    = 2'd1,
    LP_EXCP  = 2'd2
  } lp_state_e;

  typedef enum logic {
    LP_SRC_LSU  = 1'b0,
    LP_SRC_NICE = 1'b1
  } lp_src_e;

  typedef struct packed {
    logic [LP_XLEN-1:0] wdat;
    logic [4:0]         rdidx;
    logic               rdfpu;
    logic [LP_XLEN-1:0] pc;
    logic [LP_XLEN-1:0] badaddr;
    logic               buserr;
  } lp_payload_t;

  // The buffer can take a new entry if it is empty or drains this cycle.
  function automatic logic lp_can_accept(input lp_state_e st,
                                         input logic wb_ready,
                                         input logic excp_ready);
    return (st == LP_EMPTY) ||
           ((st == LP_WB) && wb_ready) ||
           ((st == LP_EXCP) && excp_ready);
  endfunction

endpackage

// File: rtl/e203_longp_hang_cnt.sv
// Hang watchdog: counts cycles with a non-empty OITF and no retirement,
// saturating; the flag is a registered copy of "counter at max".
module e203_longp_hang_cnt #(
  parameter int unsigned HANG_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic hang
);

  localparam logic [HANG_W-1:0] CNT_MAX = '1;

  logic [HANG_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      hang  <= 1'b0;
    end else begin
      hang <= (cnt_q == CNT_MAX);
      if (clr) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/e203_exu_longp_retire.sv
// Long-pipe retire stage: matches LSU/NICE completions against the OITF
// head, pops it, and holds the result in a one-entry writeback/exception buffer.
module e203_exu_longp_retire
  import e203_longp_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ITAG_W = 1,
  parameter int unsigned HANG_W = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              oitf_empty,
  input  logic [ITAG_W-1:0] ret_ptr,
  input  logic [4:0]        ret_rdidx,
  input  logic              ret_rdwen,
  input  logic              ret_rdfpu,
  input  logic [XLEN-1:0]   ret_pc,
  output logic              ret_ena,

  input  logic              lsu_wbck_i_valid,
  output logic              lsu_wbck_i_ready,
  input  logic [XLEN-1:0]   lsu_wbck_i_wdat,
  input  logic [XLEN-1:0]   lsu_wbck_i_badaddr,
  input  logic [ITAG_W-1:0] lsu_wbck_i_itag,
  input  logic              lsu_wbck_i_err,

  input  logic              nice_wbck_i_valid,
  output logic              nice_wbck_i_ready,
  input  logic [XLEN-1:0]   nice_wbck_i_wdat,
  input  logic [ITAG_W-1:0] nice_wbck_i_itag,
  input  logic              nice_wbck_i_err,

  output logic              longp_wbck_o_valid,
  input  logic              longp_wbck_o_ready,
  output logic [XLEN-1:0]   longp_wbck_o_wdat,
  output logic [4:0]        longp_wbck_o_rdidx,
  output logic              longp_wbck_o_rdfpu,

  output logic              longp_excp_o_valid,
  input  logic              longp_excp_o_ready,
  output logic [XLEN-1:0]   longp_excp_o_pc,
  output logic [XLEN-1:0]   longp_excp_o_badaddr,
  output logic              longp_excp_o_buserr,

  output logic              longp_hang
);

  lp_state_e   state_q, state_d;
  lp_payload_t pl_q, pl_d;

  logic      can_acc;
  logic      lsu_hit;
  logic      nice_hit;
  logic      acc;
  lp_src_e   src;
  logic      src_err;

  // Both sources eligible at once is illegal upstream; LSU still wins.
  always_comb begin
    can_acc  = lp_can_accept(state_q, longp_wbck_o_ready, longp_excp_o_ready);
    lsu_hit  = !rst && lsu_wbck_i_valid && (lsu_wbck_i_itag == ret_ptr)
               && !oitf_empty && can_acc;
    nice_hit = !rst && nice_wbck_i_valid && (nice_wbck_i_itag == ret_ptr)
               && !oitf_empty && can_acc && !lsu_hit;
    acc      = lsu_hit || nice_hit;
    src      = lsu_hit ? LP_SRC_LSU : LP_SRC_NICE;
    src_err  = lsu_hit ? lsu_wbck_i_err : nice_wbck_i_err;
  end

  assign ret_ena           = acc;
  assign lsu_wbck_i_ready  = lsu_hit;
  assign nice_wbck_i_ready = nice_hit;

  always_comb begin
    state_d = state_q;
    pl_d    = pl_q;
    if (can_acc) begin
      state_d = LP_EMPTY;
    end
    if (acc) begin
      if (src_err) begin
        state_d        = LP_EXCP;
        pl_d.pc        = LP_XLEN'(ret_pc);
        pl_d.badaddr   = (src == LP_SRC_LSU) ? LP_XLEN'(lsu_wbck_i_badaddr) : '0;
        pl_d.buserr    = (src == LP_SRC_LSU);
      end else if (ret_rdwen) begin
        state_d        = LP_WB;
        pl_d.wdat      = (src == LP_SRC_LSU) ? LP_XLEN'(lsu_wbck_i_wdat)
                                             : LP_XLEN'(nice_wbck_i_wdat);
        pl_d.rdidx     = ret_rdidx;
        pl_d.rdfpu     = ret_rdfpu;
      end else begin
        state_d        = LP_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LP_EMPTY;
      pl_q    <= '0;
    end else begin
      state_q <= state_d;
      pl_q    <= pl_d;
    end
  end

  assign longp_wbck_o_valid   = (state_q == LP_WB);
  assign longp_wbck_o_wdat    = XLEN'(pl_q.wdat);
  assign longp_wbck_o_rdidx   = pl_q.rdidx;
  assign longp_wbck_o_rdfpu   = pl_q.rdfpu;
  assign longp_excp_o_valid   = (state_q == LP_EXCP);
  assign longp_excp_o_pc      = XLEN'(pl_q.pc);
  assign longp_excp_o_badaddr = XLEN'(pl_q.badaddr);
  assign longp_excp_o_buserr  = pl_q.buserr;

  e203_longp_hang_cnt #(
    .HANG_W(HANG_W)
  ) u_hang_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc || oitf_empty),
    .hang (longp_hang)
  );

endmodule

// File: tb/tb_e203_exu_longp_retire.sv
// Bench for the long-pipe retire stage: directed scenarios with literal
// expectations, then random traffic against a pending-result model.
module tb_e203_exu_longp_retire;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned HANG_W = 4;
  localparam int          HMAX   = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            oitf_empty;
  logic [0:0]      ret_ptr;
  logic [4:0]      ret_rdidx;
  logic            ret_rdwen;
  logic            ret_rdfpu;
  logic [XLEN-1:0] ret_pc;
  logic            ret_ena;
  logic            lsu_valid, lsu_ready, lsu_err;
  logic [XLEN-1:0] lsu_wdat, lsu_bad;
  logic [0:0]      lsu_itag;
  logic            nice_valid, nice_ready, nice_err;
  logic [XLEN-1:0] nice_wdat;
  logic [0:0]      nice_itag;
  logic            wb_valid, wb_rdy, wb_rdfpu;
  logic [XLEN-1:0] wb_wdat;
  logic [4:0]      wb_rdidx;
  logic            ex_valid, ex_rdy, ex_buserr;
  logic [XLEN-1:0] ex_pc, ex_bad;
  logic            hang;

  always #5 clk = ~clk;

  e203_exu_longp_retire #(
    .XLEN(XLEN),
    .ITAG_W(1),
    .HANG_W(HANG_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .oitf_empty          (oitf_empty),
    .ret_ptr             (ret_ptr),
    .ret_rdidx           (ret_rdidx),
    .ret_rdwen           (ret_rdwen),
    .ret_rdfpu           (ret_rdfpu),
    .ret_pc              (ret_pc),
    .ret_ena             (ret_ena),
    .lsu_wbck_i_valid    (lsu_valid),
    .lsu_wbck_i_ready    (lsu_ready),
    .lsu_wbck_i_wdat     (lsu_wdat),
    .lsu_wbck_i_badaddr  (lsu_bad),
    .lsu_wbck_i_itag     (lsu_itag),
    .lsu_wbck_i_err      (lsu_err),
    .nice_wbck_i_valid   (nice_valid),
    .nice_wbck_i_ready   (nice_ready),
    .nice_wbck_i_wdat    (nice_wdat),
    .nice_wbck_i_itag    (nice_itag),
    .nice_wbck_i_err     (nice_err),
    .longp_wbck_o_valid  (wb_valid),
    .longp_wbck_o_ready  (wb_rdy),
    .longp_wbck_o_wdat   (wb_wdat),
    .longp_wbck_o_rdidx  (wb_rdidx),
    .longp_wbck_o_rdfpu  (wb_rdfpu),
    .longp_excp_o_valid  (ex_valid),
    .longp_excp_o_ready  (ex_rdy),
    .longp_excp_o_pc     (ex_pc),
    .longp_excp_o_badaddr(ex_bad),
    .longp_excp_o_buserr (ex_buserr),
    .longp_hang          (hang)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: what the one-entry buffer holds (0 none, 1 writeback, 2 exception),
  // plus the length of the current no-retire run for the watchdog.
  int              m_kind;
  logic [XLEN-1:0] m_wdat, m_pc, m_bad;
  logic [4:0]      m_rdidx;
  logic            m_rdfpu, m_buserr;
  int              m_idle;
  logic            m_hang;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic quiet();
    oitf_empty = 1'b1; ret_ptr = 1'b0; ret_rdidx = '0; ret_rdwen = 1'b0;
    ret_rdfpu = 1'b0; ret_pc = '0;
    lsu_valid = 1'b0; lsu_wdat = '0; lsu_bad = '0; lsu_itag = 1'b0; lsu_err = 1'b0;
    nice_valid = 1'b0; nice_wdat = '0; nice_itag = 1'b0; nice_err = 1'b0;
    wb_rdy = 1'b1; ex_rdy = 1'b1;
  endtask

  // Called at negedge with inputs applied: check every output, advance the
  // model across the next posedge, return at the following negedge.
  task automatic step();
    logic ok, e_lsu, e_nice, e_ret;
    #1;
    ok     = (m_kind == 0) || (m_kind == 1 && wb_rdy) || (m_kind == 2 && ex_rdy);
    e_lsu  = !rst && lsu_valid && (lsu_itag == ret_ptr) && !oitf_empty && ok;
    e_nice = !rst && nice_valid && (nice_itag == ret_ptr) && !oitf_empty && ok && !e_lsu;
    e_ret  = e_lsu || e_nice;
    chk("ret_ena", ret_ena, e_ret);
    chk("lsu_ready", lsu_ready, e_lsu);
    chk("nice_ready", nice_ready, e_nice);
    chk("wbck_valid", wb_valid, m_kind == 1);
    if (m_kind == 1) begin
      chk("wbck_wdat", wb_wdat, m_wdat);
      chk("wbck_rdidx", wb_rdidx, m_rdidx);
      chk("wbck_rdfpu", wb_rdfpu, m_rdfpu);
    end
    chk("excp_valid", ex_valid, m_kind == 2);
    if (m_kind == 2) begin
      chk("excp_pc", ex_pc, m_pc);
      chk("excp_badaddr", ex_bad, m_bad);
      chk("excp_buserr", ex_buserr, m_buserr);
    end
    chk("hang", hang, m_hang);
    if (rst) begin
      m_kind = 0; m_idle = 0; m_hang = 1'b0;
    end else begin
      m_hang = (m_idle == HMAX);
      if (e_ret || oitf_empty) m_idle = 0;
      else if (m_idle < HMAX) m_idle++;
      if (e_ret) begin
        if (e_lsu ? lsu_err : nice_err) begin
          m_kind = 2; m_pc = ret_pc; m_bad = e_lsu ? lsu_bad : '0; m_buserr = e_lsu;
        end else if (ret_rdwen) begin
          m_kind = 1; m_wdat = e_lsu ? lsu_wdat : nice_wdat;
          m_rdidx = ret_rdidx; m_rdfpu = ret_rdfpu;
        end else begin
          m_kind = 0;
        end
      end else if (ok) begin
        m_kind = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    m_kind = 0; m_idle = 0; m_hang = 1'b0;
    m_wdat = '0; m_pc = '0; m_bad = '0; m_rdidx = '0; m_rdfpu = 1'b0; m_buserr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lsu_valid = 1'b1; oitf_empty = 1'b0;
    #1;
    chk("rst_ret_ena", ret_ena, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    step();
    quiet();
    rst = 1'b0;
    chk("rst_wbck_valid", wb_valid, 0);
    chk("rst_excp_valid", ex_valid, 0);
    chk("rst_hang", hang, 0);

    // LSU writeback, latency 1
    oitf_empty = 1'b0; ret_ptr = 1'b0; ret_rdwen = 1'b1; ret_rdidx = 5'd5;
    lsu_valid = 1'b1; lsu_itag = 1'b0; lsu_wdat = 32'hDEADBEEF;
    #1;
    chk("t1_ret_ena", ret_ena, 1);
    step();
    lsu_valid = 1'b0;
    #1;
    chk("t1_wbck_valid", wb_valid, 1);
    chk("t1_wbck_rdidx", wb_rdidx, 5);
    chk("t1_wbck_wdat", wb_wdat, 32'hDEADBEEF);
    step();

    // itag mismatch holds the source until the head matches
    lsu_valid = 1'b1; lsu_itag = 1'b1; ret_ptr = 1'b0; lsu_wdat = 32'h11;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t2_lsu_ready", lsu_ready, 0);
      chk("t2_ret_ena", ret_ena, 0);
      step();
    end
    ret_ptr = 1'b1;
    #1;
    chk("t2_ret_ena_match", ret_ena, 1);
    step();
    lsu_valid = 1'b0;

    // NICE error, exception stalled by commit
    nice_valid = 1'b1; nice_itag = 1'b1; nice_err = 1'b1; ret_pc = 32'h80000040; ex_rdy = 1'b0;
    step();
    ret_pc = 32'h80000044;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_excp_valid", ex_valid, 1);
      chk("t3_excp_pc", ex_pc, 32'h80000040);
      chk("t3_excp_badaddr", ex_bad, 0);
      chk("t3_excp_buserr", ex_buserr, 0);
      chk("t3_ret_ena", ret_ena, 0);
      step();
    end
    nice_valid = 1'b0; nice_err = 1'b0; ex_rdy = 1'b1;
    step();

    // Back-to-back LSU then NICE
    ret_ptr = 1'b0; ret_rdidx = 5'd7; lsu_valid = 1'b1; lsu_itag = 1'b0; lsu_wdat = 32'hA;
    #1;
    chk("t4_ret_ena_a", ret_ena, 1);
    step();
    lsu_valid = 1'b0; ret_ptr = 1'b1; ret_rdidx = 5'd8;
    nice_valid = 1'b1; nice_itag = 1'b1; nice_wdat = 32'hB;
    #1;
    chk("t4_ret_ena_b", ret_ena, 1);
    chk("t4_wbck_valid_a", wb_valid, 1);
    chk("t4_wbck_wdat_a", wb_wdat, 32'hA);
    step();
    nice_valid = 1'b0; oitf_empty = 1'b1;
    #1;
    chk("t4_wbck_valid_b", wb_valid, 1);
    chk("t4_wbck_wdat_b", wb_wdat, 32'hB);
    step();

    // Watchdog
    quiet();
    step();
    oitf_empty = 1'b0;
    repeat (15) step();
    chk("t5_hang_early", hang, 0);
    step();
    chk("t5_hang_set", hang, 1);
    lsu_valid = 1'b1; lsu_itag = ret_ptr;
    step();
    lsu_valid = 1'b0;
    step();
    chk("t5_hang_clear", hang, 0);

    // Reset while holding a writeback
    lsu_valid = 1'b1; lsu_itag = ret_ptr; ret_rdwen = 1'b1; wb_rdy = 1'b0;
    step();
    lsu_valid = 1'b0;
    chk("t6_wbck_valid", wb_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_wbck_valid_rst", wb_valid, 0);
    step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      oitf_empty = ($urandom_range(0, 5) == 0);
      ret_ptr    = 1'($urandom);
      ret_rdidx  = 5'($urandom);
      ret_rdwen  = 1'($urandom);
      ret_rdfpu  = 1'($urandom);
      ret_pc     = $urandom;
      lsu_valid  = ($urandom_range(0, 2) == 0);
      lsu_itag   = ($urandom_range(0, 9) < 7) ? ret_ptr : ~ret_ptr;
      lsu_wdat   = $urandom;
      lsu_bad    = $urandom;
      lsu_err    = ($urandom_range(0, 7) == 0);
      nice_valid = ($urandom_range(0, 2) == 0);
      nice_itag  = ($urandom_range(0, 9) < 7) ? ret_ptr : ~ret_ptr;
      nice_wdat  = $urandom;
      nice_err   = ($urandom_range(0, 7) == 0);
      wb_rdy     = ($urandom_range(0, 9) < 7);
      ex_rdy     = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
